// File: rtl/shifter_pkg.sv
// Shared encodings for the sequential shifter: operation modes, FSM states, field widths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package shifter_pkg;

  localparam int OP_W = 2;
  localparam int ST_W = 2;

  typedef enum logic [OP_W-1:0] {
    OP_LSL = 2'b00,
    OP_LSR = 2'b01,
    OP_ASR = 2'b10,
    OP_ROR = 2'b11
  } op_e;

  typedef enum logic [ST_W-1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/shift_step.sv
// One partial shift step: moves data by k bits (k <= STEP) in the selected mode.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
//
// Ports:
//   din  : data before this step
//   op   : shift mode
//   k    : distance for this step (never larger than the remaining amount)
//   dout : data after this step
//   cout : last bit pushed out by this step (0 when k==0)
module shift_step
  import shifter_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] din,
  input  op_e              op,
  input  logic [SHW-1:0]   k,
  output logic [WIDTH-1:0] dout,
  output logic             cout
);

  // Each mode works on a vector one bit wider than the data; the extra bit
  // catches the last bit shifted out, so cout falls out of the same shift.
  logic [WIDTH:0] lsl_w;
  logic [WIDTH:0] lsr_w;
  logic [WIDTH:0] asr_w;
  logic [WIDTH:0] ror_w;

  always_comb begin
    lsl_w = {1'b0, din} << k;
    lsr_w = {din, 1'b0} >> k;
    asr_w = $unsigned($signed({din, 1'b0}) >>> k);
    // Two copies of din let the low bits wrap into the top on a right shift.
    ror_w = (WIDTH+1)'({din, din, 1'b0} >> k);

    dout = din;
    cout = 1'b0;
    case (op)
      OP_LSL: begin
        dout = lsl_w[WIDTH-1:0];
        cout = lsl_w[WIDTH];
      end
      OP_LSR: begin
        dout = lsr_w[WIDTH:1];
        cout = lsr_w[0];
      end
      OP_ASR: begin
        dout = asr_w[WIDTH:1];
        cout = asr_w[0];
      end
      OP_ROR: begin
        dout = ror_w[WIDTH:1];
        cout = ror_w[0];
      end
      default: begin
        dout = din;
        cout = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/seq_shifter.sv
// Multi-cycle shifter (LSL/LSR/ASR/ROR) moving up to STEP bits per clock.
// Latency: ceil(shr/STEP)+1 cycles from the start cycle to done; shr==0 gives 1 cycle.
// Backpressure: start is only honoured in IDLE; starts while busy or in DONE are dropped.
//
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   start    : request, with op/A/shr captured in the same cycle
//   busy     : high while shift steps are in progress
//   done     : one-cycle pulse when OUT/cout carry a new result
//   OUT/cout : result and last bit shifted out, held until the next result
module seq_shifter
  import shifter_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH),
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [SHW-1:0]   shr,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] OUT,
  output logic             cout
);

  localparam logic [SHW-1:0] STEP_K = SHW'(STEP);

  state_e           state;
  state_e           state_nxt;
  logic [WIDTH-1:0] data_q;
  op_e              op_q;
  logic [SHW-1:0]   rem_q;
  logic [WIDTH-1:0] out_q;
  logic             cout_q;

  logic [SHW-1:0]   k;
  logic             last_step;
  logic [WIDTH-1:0] step_dat;
  logic             step_cout;

  // Distance for this cycle; clamping to rem keeps rem from ever wrapping.
  assign k         = (rem_q > STEP_K) ? STEP_K : rem_q;
  assign last_step = (rem_q <= STEP_K);

  shift_step #(
    .WIDTH(WIDTH),
    .SHW  (SHW)
  ) u_step (
    .din (data_q),
    .op  (op_q),
    .k   (k),
    .dout(step_dat),
    .cout(step_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = (shr == '0) ? S_DONE : S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (last_step) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Result registers are loaded on the edge that enters DONE, so they are
  // valid during the done pulse and then simply hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      op_q   <= OP_LSL;
      rem_q  <= '0;
      out_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            data_q <= A;
            op_q   <= op_e'(op);
            rem_q  <= shr;
            if (shr == '0) begin
              out_q  <= A;
              cout_q <= 1'b0;
            end
          end
        end
        S_SHIFT: begin
          data_q <= step_dat;
          rem_q  <= rem_q - k;
          if (last_step) begin
            out_q  <= step_dat;
            cout_q <= step_cout;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy = (state == S_SHIFT);
  assign done = (state == S_DONE);
  assign OUT  = out_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_seq_shifter.sv
// Bench for seq_shifter: two instances (STEP=1 and STEP=4) checked against a
// behavioural model of the shift result, carry-out and cycle timing.
module tb_seq_shifter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  start;
  logic [1:0]  op;
  logic [15:0] a;
  logic [3:0]  shr;
  logic [1:0]  busy;
  logic [1:0]  done;
  logic [1:0]  cout;
  logic [15:0] out0;
  logic [15:0] out1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  seq_shifter #(.WIDTH(16), .SHW(4), .STEP(1)) u_s1 (
    .clk(clk), .rst(rst), .start(start[0]), .op(op), .A(a), .shr(shr),
    .busy(busy[0]), .done(done[0]), .OUT(out0), .cout(cout[0])
  );

  seq_shifter #(.WIDTH(16), .SHW(4), .STEP(4)) u_s4 (
    .clk(clk), .rst(rst), .start(start[1]), .op(op), .A(a), .shr(shr),
    .busy(busy[1]), .done(done[1]), .OUT(out1), .cout(cout[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Whole-operation reference: the full shift applied in one go.
  task automatic ref_op(input logic [1:0] o, input logic [15:0] x, input int s,
                        output logic [15:0] r, output logic c);
    logic signed [15:0] sx;
    sx = x;
    r  = x;
    c  = 1'b0;
    if (s != 0) begin
      case (o)
        2'd0: begin r = x << s;  c = x[16-s]; end
        2'd1: begin r = x >> s;  c = x[s-1];  end
        2'd2: begin r = sx >>> s; c = x[s-1]; end
        default: begin r = (x >> s) | (x << (16 - s)); c = x[s-1]; end
      endcase
    end
  endtask

  // Called at a negedge with the chosen DUT idle. Returns at the negedge
  // where done is seen (the DONE cycle). inject>0 re-pulses start with
  // different operands that many cycles into the operation.
  task automatic do_op(input int sel, input logic [1:0] o, input logic [15:0] x,
                       input logic [3:0] s, input logic [15:0] eo, input logic ec,
                       input int inject, input string tag);
    int lat;
    int nbusy;
    int st;
    bit seen;
    st    = (sel != 0) ? 4 : 1;
    op    = o;
    a     = x;
    shr   = s;
    start[sel] = 1'b1;
    lat   = 0;
    nbusy = 0;
    seen  = 1'b0;
    while (!seen && lat < 100) begin
      @(negedge clk);
      lat++;
      start[sel] = 1'b0;
      if (inject != 0 && lat == inject) begin
        start[sel] = 1'b1;
        a   = ~x;
        shr = s ^ 4'h5;
        op  = 2'(o + 2'd1);
      end
      if (busy[sel]) nbusy++;
      if (done[sel]) seen = 1'b1;
    end
    start[sel] = 1'b0;
    check({tag, "_done"}, 32'(seen), 32'd1);
    check({tag, "_lat"}, 32'(lat), 32'((int'(s) + st - 1) / st + 1));
    check({tag, "_busy"}, 32'(nbusy), 32'((int'(s) + st - 1) / st));
    check({tag, "_out"}, 32'((sel != 0) ? out1 : out0), 32'(eo));
    check({tag, "_cout"}, 32'(cout[sel]), 32'(ec));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] r;
    logic        c;
    logic [1:0]  ro;
    logic [15:0] rx;
    logic [3:0]  rs;
    int          npulse;

    rst   = 1'b1;
    start = 2'b00;
    op    = 2'd0;
    a     = 16'h0;
    shr   = 4'd0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_out0", 32'(out0), 32'd0);
    check("rst_out1", 32'(out1), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed cases with hand-derived results.
    do_op(0, 2'd1, 16'h0300, 4'd8, 16'h0003, 1'b0, 0, "t1_lsr");  @(negedge clk);
    do_op(0, 2'd2, 16'h8000, 4'd4, 16'hF800, 1'b0, 0, "t2_asr");  @(negedge clk);
    do_op(0, 2'd3, 16'h0001, 4'd1, 16'h8000, 1'b1, 0, "t2_ror");  @(negedge clk);
    do_op(1, 2'd0, 16'h0300, 4'd8, 16'h0000, 1'b1, 0, "t3_lsl");  @(negedge clk);
    do_op(1, 2'd1, 16'h00F0, 4'd5, 16'h0007, 1'b1, 0, "t3_lsr");  @(negedge clk);
    do_op(0, 2'd2, 16'hBEEF, 4'd0, 16'hBEEF, 1'b0, 0, "t4_z1");   @(negedge clk);
    do_op(1, 2'd3, 16'hBEEF, 4'd0, 16'hBEEF, 1'b0, 0, "t4_z4");   @(negedge clk);

    // Start re-pulsed mid-operation, then held through DONE into IDLE.
    do_op(0, 2'd1, 16'h0300, 4'd8, 16'h0003, 1'b0, 3, "t5_mid");
    op  = 2'd0;
    a   = 16'hF0FF;
    shr = 4'd4;
    start[0] = 1'b1;
    @(negedge clk);
    check("t5_ign_done_busy", 32'(busy[0]), 32'd0);
    check("t5_ign_done_out", 32'(out0), 32'h0003);
    do_op(0, 2'd0, 16'hF0FF, 4'd4, 16'h0FF0, 1'b1, 0, "t5_next"); @(negedge clk);

    // Reset two cycles into an operation abandons it.
    op  = 2'd1;
    a   = 16'h0300;
    shr = 4'd8;
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t6_busy", 32'(busy[0]), 32'd0);
    check("t6_done", 32'(done[0]), 32'd0);
    check("t6_out", 32'(out0), 32'd0);
    check("t6_cout", 32'(cout[0]), 32'd0);
    npulse = 0;
    repeat (12) begin
      @(negedge clk);
      if (done[0]) npulse++;
    end
    check("t6_no_done", 32'(npulse), 32'd0);
    do_op(0, 2'd3, 16'h00F0, 4'd4, 16'h000F, 1'b0, 0, "t6_after"); @(negedge clk);

    // Randomized operations on both instances.
    for (int i = 0; i < 60; i++) begin
      ro = 2'($urandom_range(0, 3));
      rx = 16'($urandom);
      rs = 4'($urandom_range(0, 15));
      ref_op(ro, rx, int'(rs), r, c);
      do_op(i % 2, ro, rx, rs, r, c, 0, "rnd");
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
